// File: rtl/baby_pkg.sv
// rtl/baby_pkg.sv - shared state, opcode and ALU-op constants for the Baby control sequencer
//
// Contents:
//   state_t      sequencer states S_IDLE .. S_HALT
//   OP_*         function-bit (F) opcode values from IR[15:13]
//   ALU_*        accumulator/ALU operation select codes
//   exec_ctl_t   per-opcode execute-cycle controls produced by baby_opcode_decode
package baby_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INC    = 3'd1,
        S_FETCH  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_SKIP   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [2:0] OP_JMP     = 3'b000;
    localparam logic [2:0] OP_JRP     = 3'b001;
    localparam logic [2:0] OP_LDN     = 3'b010;
    localparam logic [2:0] OP_STO     = 3'b011;
    localparam logic [2:0] OP_SUB     = 3'b100;
    localparam logic [2:0] OP_SUB_ALT = 3'b101;
    localparam logic [2:0] OP_CMP     = 3'b110;
    localparam logic [2:0] OP_STP     = 3'b111;

    localparam logic [2:0] ALU_PASS    = 3'd0;
    localparam logic [2:0] ALU_NEG     = 3'd1;
    localparam logic [2:0] ALU_SUB     = 3'd2;
    localparam logic [2:0] ALU_ADD_PC  = 3'd3;
    localparam logic [2:0] ALU_STORE_A = 3'd4;
    localparam logic [2:0] ALU_NOP     = 3'd7;

    // pc_load is active-high here; the top inverts it onto PC_LOAD_n.
    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       pc_load;
        logic       acc_load;
        logic [2:0] alu_op;
    } exec_ctl_t;

endpackage

// File: rtl/baby_control_sequencer_if.sv
// rtl/baby_control_sequencer_if.sv - control/status bundle between sequencer, front panel and datapath
//
// Signals:
//   RUN, STOP           front-panel levels into the sequencer
//   OPCODE, ACC_NEG     datapath status into the sequencer (IR[15:13], ACC[31])
//   PC_COUNT, PC_LOAD_n, PC_OE_n, MEM_RD, MEM_WR, IR_LOAD, ALU_OP, ACC_LOAD, HALTED
//                       controls out of the sequencer
// Modports:
//   master  the sequencer side
//   slave   the panel/datapath side
interface baby_control_sequencer_if;

    logic       RUN;
    logic       STOP;
    logic [2:0] OPCODE;
    logic       ACC_NEG;

    logic       PC_COUNT;
    logic       PC_LOAD_n;
    logic       PC_OE_n;
    logic       MEM_RD;
    logic       MEM_WR;
    logic       IR_LOAD;
    logic [2:0] ALU_OP;
    logic       ACC_LOAD;
    logic       HALTED;

    modport master (
        input  RUN, STOP, OPCODE, ACC_NEG,
        output PC_COUNT, PC_LOAD_n, PC_OE_n, MEM_RD, MEM_WR, IR_LOAD, ALU_OP, ACC_LOAD, HALTED
    );

    modport slave (
        output RUN, STOP, OPCODE, ACC_NEG,
        input  PC_COUNT, PC_LOAD_n, PC_OE_n, MEM_RD, MEM_WR, IR_LOAD, ALU_OP, ACC_LOAD, HALTED
    );

endinterface

// File: rtl/baby_opcode_decode.sv
// rtl/baby_opcode_decode.sv - combinational opcode to execute-cycle control decode
//
// Ports:
//   opcode  in   3  registered function bits F
//   ctl     out  exec_ctl_t  {mem_rd, mem_wr, pc_load, acc_load, alu_op} for the S_EXEC cycle
// The caller gates ctl with its execute state; this block knows nothing about timing.
module baby_opcode_decode
    import baby_pkg::*;
(
    input  logic [2:0] opcode,
    output exec_ctl_t  ctl
);

    always_comb begin
        ctl = '{mem_rd: 1'b0, mem_wr: 1'b0, pc_load: 1'b0, acc_load: 1'b0, alu_op: ALU_NOP};
        case (opcode)
            OP_JMP: begin
                ctl.mem_rd  = 1'b1;
                ctl.alu_op  = ALU_PASS;
                ctl.pc_load = 1'b1;
            end
            OP_JRP: begin
                ctl.mem_rd  = 1'b1;
                ctl.alu_op  = ALU_ADD_PC;
                ctl.pc_load = 1'b1;
            end
            OP_LDN: begin
                ctl.mem_rd   = 1'b1;
                ctl.alu_op   = ALU_NEG;
                ctl.acc_load = 1'b1;
            end
            OP_STO: begin
                ctl.mem_wr = 1'b1;
                ctl.alu_op = ALU_STORE_A;
            end
            OP_SUB, OP_SUB_ALT: begin
                ctl.mem_rd   = 1'b1;
                ctl.alu_op   = ALU_SUB;
                ctl.acc_load = 1'b1;
            end
            default: ;  // CMP and STP only affect sequencing
        endcase
    end

endmodule

// File: rtl/baby_control_sequencer.sv
// rtl/baby_control_sequencer.sv - fetch/execute control sequencer for the Manchester Baby datapath
//
// Ports:
//   CLK      in   system clock, rising edge
//   RESET_n  in   synchronous active-low reset
//   STEP     in   single-step pulse (only when SINGLE_STEP_EN is defined)
//   bus      baby_control_sequencer_if.master: RUN/STOP/OPCODE/ACC_NEG in, PC/store/IR/ALU controls out
// Optional feature macro: SINGLE_STEP_EN - adds STEP; without RUN the sequencer returns to S_IDLE
// after every instruction and starts the next one on a STEP rising edge.
// All outputs decode from state_q/opcode_q only; ACC_NEG, RUN, STOP and STEP feed next-state only.
module baby_control_sequencer
    import baby_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RESET_n,
`ifdef SINGLE_STEP_EN
    input  logic                      STEP,
`endif
    baby_control_sequencer_if.master  bus
);

    state_t     state_q, state_d;
    logic [2:0] opcode_q, opcode_d;
    exec_ctl_t  dec_ctl;
    logic       start_go;
    logic       continue_go;

`ifdef SINGLE_STEP_EN
    logic step_q, step_d;

    assign step_d      = STEP;
    assign start_go    = bus.RUN | (STEP & ~step_q);
    // Without RUN, each instruction ends back in S_IDLE to wait for the next STEP.
    assign continue_go = bus.RUN & ~bus.STOP;

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step_d;
        end
    end
`else
    assign start_go    = bus.RUN;
    assign continue_go = ~bus.STOP;
`endif

    baby_opcode_decode u_decode (
        .opcode (opcode_q),
        .ctl    (dec_ctl)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state_q  <= S_IDLE;
            opcode_q <= OP_JMP;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            S_IDLE:   if (start_go) state_d = S_INC;
            S_INC:    state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                // IR has been loaded by now; capture F so S_EXEC is independent of the live input.
                opcode_d = bus.OPCODE;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                // STP is checked first so a simultaneous STOP still lands in S_HALT.
                if (opcode_q == OP_STP) begin
                    state_d = S_HALT;
                end else if (opcode_q == OP_CMP && bus.ACC_NEG) begin
                    state_d = S_SKIP;
                end else if (continue_go) begin
                    state_d = S_INC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SKIP:   state_d = continue_go ? S_INC : S_IDLE;
            S_HALT:   if (!bus.RUN) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    logic       pc_count_c, pc_load_c, pc_oe_c, mem_rd_c, mem_wr_c, ir_load_c, acc_load_c, halted_c;
    logic [2:0] alu_op_c;

    always_comb begin
        pc_count_c = 1'b0;
        pc_load_c  = 1'b0;
        pc_oe_c    = 1'b0;
        mem_rd_c   = 1'b0;
        mem_wr_c   = 1'b0;
        ir_load_c  = 1'b0;
        acc_load_c = 1'b0;
        alu_op_c   = ALU_NOP;
        halted_c   = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: halted_c = 1'b1;
            S_INC, S_SKIP:  pc_count_c = 1'b1;
            S_FETCH: begin
                pc_oe_c   = 1'b1;
                mem_rd_c  = 1'b1;
                ir_load_c = 1'b1;
            end
            S_EXEC: begin
                mem_rd_c   = dec_ctl.mem_rd;
                mem_wr_c   = dec_ctl.mem_wr;
                pc_load_c  = dec_ctl.pc_load;
                acc_load_c = dec_ctl.acc_load;
                alu_op_c   = dec_ctl.alu_op;
            end
            default: ;
        endcase
    end

    assign bus.PC_COUNT  = pc_count_c;
    assign bus.PC_LOAD_n = ~pc_load_c;
    assign bus.PC_OE_n   = ~pc_oe_c;
    assign bus.MEM_RD    = mem_rd_c;
    assign bus.MEM_WR    = mem_wr_c;
    assign bus.IR_LOAD   = ir_load_c;
    assign bus.ALU_OP    = alu_op_c;
    assign bus.ACC_LOAD  = acc_load_c;
    assign bus.HALTED    = halted_c;

endmodule

// File: tb/tb_baby_control_sequencer.sv
// tb/tb_baby_control_sequencer.sv - randomized instruction-level bench for baby_control_sequencer
module tb_baby_control_sequencer;

    logic CLK = 1'b0;
    logic RESET_n;
`ifdef SINGLE_STEP_EN
    logic STEP;
`endif

    int checks = 0;
    int errors = 0;

    baby_control_sequencer_if bus();

    baby_control_sequencer dut (
        .CLK     (CLK),
        .RESET_n (RESET_n),
`ifdef SINGLE_STEP_EN
        .STEP    (STEP),
`endif
        .bus     (bus.master)
    );

    always #5 CLK = ~CLK;

    // Output vector: {HALTED, PC_COUNT, PC_LOAD_n, PC_OE_n, MEM_RD, MEM_WR, IR_LOAD, ALU_OP[2:0], ACC_LOAD}
    function automatic logic [10:0] v(logic h, logic pcc, logic pcl_n, logic oe_n, logic rd,
                                      logic wr, logic irl, logic [2:0] alu, logic accl);
        return {h, pcc, pcl_n, oe_n, rd, wr, irl, alu, accl};
    endfunction

    logic [10:0] v_idle, v_inc, v_fetch, v_dec;

    // Execute-cycle controls per opcode, straight from the instruction table.
    function automatic logic [10:0] v_exec(logic [2:0] op);
        case (op)
            3'd0:    return v(0, 0, 0, 1, 1, 0, 0, 3'd0, 0);
            3'd1:    return v(0, 0, 0, 1, 1, 0, 0, 3'd3, 0);
            3'd2:    return v(0, 0, 1, 1, 1, 0, 0, 3'd1, 1);
            3'd3:    return v(0, 0, 1, 1, 0, 1, 0, 3'd4, 0);
            3'd4,
            3'd5:    return v(0, 0, 1, 1, 1, 0, 0, 3'd2, 1);
            default: return v(0, 0, 1, 1, 0, 0, 0, 3'd7, 0);
        endcase
    endfunction

    function automatic logic [10:0] observed();
        return {bus.HALTED, bus.PC_COUNT, bus.PC_LOAD_n, bus.PC_OE_n, bus.MEM_RD,
                bus.MEM_WR, bus.IR_LOAD, bus.ALU_OP, bus.ACC_LOAD};
    endfunction

    task automatic cyc(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        @(posedge CLK);
        #1;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Runs one instruction starting from a state whose next edge enters S_INC.
    // Returns with the sequencer again about to enter S_INC (RUN=1, STOP=0).
    task automatic run_instr(input logic [2:0] op, input logic neg, input logic stop);
        cyc("inc", v_inc);
        bus.OPCODE  = op;
        bus.ACC_NEG = neg;
        bus.STOP    = stop;
        cyc("fetch", v_fetch);
        cyc("decode", v_dec);
        cyc($sformatf("exec_op%0d", op), v_exec(op));
        if (op == 3'd7) begin
            cyc("halt", v_idle);
            for (int k = 0; k < 3; k++) cyc("halt_hold_run", v_idle);
            bus.RUN  = 1'b0;
            bus.STOP = 1'b0;
            cyc("halt_to_idle", v_idle);
            cyc("idle_after_halt", v_idle);
            bus.RUN = 1'b1;
        end else begin
            if (op == 3'd6 && neg) cyc("skip", v_inc);
            if (stop) begin
                cyc("stop_idle", v_idle);
                bus.STOP = 1'b0;
                bus.RUN  = 1'b0;
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) cyc("idle_wait", v_idle);
                bus.RUN = 1'b1;
            end
        end
    endtask

    initial begin
        logic [2:0] op;
        logic       neg;
        logic       stop;

        v_idle  = v(1, 0, 1, 1, 0, 0, 0, 3'd7, 0);
        v_inc   = v(0, 1, 1, 1, 0, 0, 0, 3'd7, 0);
        v_fetch = v(0, 0, 1, 0, 1, 0, 1, 3'd7, 0);
        v_dec   = v(0, 0, 1, 1, 0, 0, 0, 3'd7, 0);

        RESET_n     = 1'b0;
        bus.RUN     = 1'b0;
        bus.STOP    = 1'b0;
        bus.OPCODE  = 3'd0;
        bus.ACC_NEG = 1'b0;
`ifdef SINGLE_STEP_EN
        STEP = 1'b0;
`endif
        cyc("reset", v_idle);
        cyc("reset_hold", v_idle);
        RESET_n = 1'b1;
        cyc("idle_no_run", v_idle);
        cyc("idle_no_run2", v_idle);

        // Free-running SUB loop: 4-cycle period.
        bus.RUN = 1'b1;
        for (int i = 0; i < 3; i++) run_instr(3'd4, 1'b0, 1'b0);

        // Every opcode once, CMP both ways, then random mix.
        for (int i = 0; i < 8; i++) run_instr(i[2:0], 1'b1, 1'b0);
        run_instr(3'd6, 1'b0, 1'b0);
        run_instr(3'd6, 1'b1, 1'b1);
        run_instr(3'd7, 1'b0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            op   = 3'($urandom_range(0, 7));
            neg  = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 5) == 0);
            run_instr(op, neg, stop);
        end

        // Reset during fetch aborts the instruction.
        cyc("inc_pre_reset", v_inc);
        cyc("fetch_pre_reset", v_fetch);
        RESET_n = 1'b0;
        bus.RUN = 1'b0;
        cyc("reset_in_fetch", v_idle);
        RESET_n = 1'b1;
        cyc("idle_after_reset", v_idle);

`ifdef SINGLE_STEP_EN
        for (int i = 0; i < 3; i++) begin
            STEP = 1'b1;
            cyc("step_inc", v_inc);
            STEP = 1'b0;
            bus.OPCODE = 3'd4;
            cyc("step_fetch", v_fetch);
            cyc("step_decode", v_dec);
            cyc("step_exec", v_exec(3'd4));
            cyc("step_idle", v_idle);
            cyc("step_idle_hold", v_idle);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/baby_control_sequencer.md
# baby_control_sequencer

Fetch/execute control sequencer for the Manchester Baby datapath. Drives the program counter (PC) count/load/output-enable controls, store read/write strobes, instruction-register load and accumulator operation select. It walks each instruction through increment, fetch, decode and execute, and handles the conditional skip and the stop state. It sits between the front-panel run/stop controls and the 32-bit PC, store, IR and accumulator blocks.

## Interface
- No parameters; opcode and state encodings are fixed constants in the shared package.
- CLK  in  1  system clock; all state changes occur on the rising edge.
- RESET_n  in  1  synchronous reset, active-low, sampled on the rising edge of CLK.
- RUN  in  1  level; start or continue execution from S_IDLE.
- STOP  in  1  level; request halt at the next instruction boundary.
- OPCODE  in  3  function bits F (IR bits 15:13), valid once IR_LOAD has taken effect.
- ACC_NEG  in  1  accumulator bit 31; sampled in S_EXEC for CMP.
- PC_COUNT  out  1  PC count enable for one cycle.
- PC_LOAD_n  out  1  PC parallel load from the ALU result, active-low.
- PC_OE_n  out  1  PC drives the store address bus, active-low; when high, the address comes from the IR line field.
- MEM_RD / MEM_WR  out  1 each  store read and write strobes.
- IR_LOAD  out  1  latch the store data into the IR.
- ALU_OP  out  3  PASS=0, NEG=1, SUB=2, ADD_PC=3, STORE_A=4, NOP=7.
- ACC_LOAD  out  1  write the ALU result into the accumulator.
- HALTED  out  1  high in S_IDLE and S_HALT.
- STEP  in  1  single-step pulse; present only with SINGLE_STEP_EN.

## Operation
- States: S_IDLE, S_INC, S_FETCH, S_DECODE, S_EXEC, S_SKIP, S_HALT. Each state lasts one cycle; S_IDLE and S_HALT wait.
- S_IDLE: all strobes inactive, PC_OE_n=1, PC_LOAD_n=1. Go to S_INC when RUN=1.
- S_INC: PC_COUNT=1. The Baby increments CI before fetching.
- S_FETCH: PC_OE_n=0, MEM_RD=1, IR_LOAD=1.
- S_DECODE: PC_OE_n=1. OPCODE is registered internally for use in S_EXEC.
- S_EXEC actions by opcode:
  - 000 JMP: MEM_RD=1, ALU_OP=PASS, PC_LOAD_n=0.
  - 001 JRP: MEM_RD=1, ALU_OP=ADD_PC, PC_LOAD_n=0.
  - 010 LDN: MEM_RD=1, ALU_OP=NEG, ACC_LOAD=1.
  - 011 STO: MEM_WR=1, ALU_OP=STORE_A.
  - 100 and 101 SUB: MEM_RD=1, ALU_OP=SUB, ACC_LOAD=1.
  - 110 CMP: no strobes. Go to S_SKIP if ACC_NEG=1, else to S_INC.
  - 111 STP: go to S_HALT.
- After S_EXEC (except CMP-taken and STP), go to S_INC. If STOP=1, go to S_IDLE instead.
- S_SKIP: PC_COUNT=1, then S_INC, so the PC advances by two in total. STOP is honoured here in the same way as after S_EXEC.
- S_HALT: hold until RUN falls to 0, then go to S_IDLE. This prevents an immediate restart while RUN is still held.
- PC arithmetic is 32-bit with wrap (0xFFFFFFFF → 0x00000000) and is owned by the PC; the sequencer only sequences it.

## Timing
- Reset: state=S_IDLE, HALTED=1, PC_LOAD_n=1, PC_OE_n=1; PC_COUNT, MEM_RD, MEM_WR, IR_LOAD, ACC_LOAD all 0; ALU_OP=NOP.
- Reset taken mid-instruction aborts it at the next edge; no strobe persists past that edge.
- All outputs are decoded combinationally from the registered state and the registered opcode; no input-to-output combinational path except ACC_NEG, which only feeds next-state.
- Instruction latency: 4 cycles (INC, FETCH, DECODE, EXEC); 5 cycles for CMP-taken. The first S_INC occurs 1 cycle after RUN is seen in S_IDLE.
- MEM_WR and PC_LOAD_n never assert together. PC_COUNT and PC_LOAD_n are never both active.
- STOP and STP in the same instruction: STP wins → S_HALT.

## Configuration
- SINGLE_STEP_EN defined:
  - Adds the STEP input.
  - After S_EXEC/S_SKIP the sequencer returns to S_IDLE and holds there until a STEP rising edge, then executes exactly one instruction.
  - RUN=1 still selects free-running operation.
- SINGLE_STEP_EN undefined: STEP port absent; behaviour exactly as above.

## Structure
- Shared package baby_pkg: state enumeration, opcode constants (OP_JMP…OP_STP), ALU_OP codes.
- One sub-module, baby_opcode_decode: combinational OPCODE → {mem_rd, mem_wr, pc_load, acc_load, alu_op}. The sequencer gates its outputs with S_EXEC.

## Test plan
- Reset, then RUN=1: HALTED 1→0; PC_COUNT at cycle 1, IR_LOAD+PC_OE_n=0 at cycle 2, loop period 4 cycles with OPCODE=100.
- OPCODE=000 (JMP): S_EXEC shows PC_LOAD_n=0, ALU_OP=PASS, MEM_RD=1, PC_COUNT=0.
- OPCODE=110 with ACC_NEG=1: extra PC_COUNT cycle (S_SKIP), total 5 cycles; with ACC_NEG=0 the instruction takes 4 cycles.
- OPCODE=111: HALTED=1 after S_EXEC, no further strobes while RUN=1; RUN=0 then 1 restarts from S_INC.
- RESET_n=0 during S_FETCH: next cycle all outputs at reset values, MEM_RD=0.
- SINGLE_STEP_EN with RUN=0: each STEP pulse yields exactly one PC_COUNT and one IR_LOAD, then HALTED=1.
